instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
Responder end of instr_memory_if, serving the IF stage.
- Returns the instruction word for the PC the IF stage presents.
- Holds a word-addressed instruction RAM, filled after reset through a byte-serial valid/ready loader stream.
- Holds the core via core_hold until a load session completes.
- Sits between the boot/debug byte source and the pipeline's fetch path.

Parameters:
ADDR_W, 10, word-address width; memory depth = 2**ADDR_W words
NOP_WORD, 32'h00000013, word returned when no valid instruction is available
START_HELD, 1, 1: after reset, core held until first load completes; 0: start in RUN

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
instr_memory_if  modport memory  -  pc input 32 from IF; instr output 32 to IF
load_start  input  1  single-cycle pulse; begins (or restarts) a load session
load_valid  input  1  load_byte valid
load_byte  input  8  loader data byte
load_ready  output  1  responder accepts a byte this cycle
core_hold  output  1  high = pipeline must stall/hold (state != RUN)
words_loaded  output  ADDR_W+1  data words accepted in current/last session
overflow  output  1  sticky: session declared more words than depth

Behaviour:
- Reset (reset=0, async): state = START_HELD ? HOLD : RUN; byte_cnt=0; word_cnt=0; declared_n=0; words_loaded=0; overflow=0; load_ready=0; core_hold = START_HELD. RAM contents are not cleared.
- States:
  - HOLD: idle, core held.
  - HDR: collecting 4-byte word count N.
  - DATA: collecting N words.
  - RUN: core free.
- Transfer: occurs on the edge where load_valid && load_ready. load_ready=1 only in HDR and DATA, combinational from state.
- load_start, any state: next state HDR; byte_cnt=0; word_cnt=0; words_loaded=0; overflow=0. load_start outranks a simultaneous transfer; that byte is dropped.
- HDR: bytes assembled little-endian (first byte -> bits 7:0). On the 4th byte, declared_n is latched.
  - N=0: go directly to RUN.
  - Otherwise: go to DATA.
  - overflow set if N > 2**ADDR_W.
- DATA: bytes assembled little-endian into a word buffer. On the 4th byte:
  - If word_cnt < 2**ADDR_W, write the word to RAM[word_cnt]. Beyond depth, discard the word (bytes still consumed).
  - word_cnt and words_loaded increment; words_loaded saturates at 2**ADDR_W.
  - When word_cnt reaches N, go to RUN.
- Write-to-read latency: a word written on edge k is visible on instr from cycle k+1.
- Read path (combinational from pc, zero-cycle):
  - instr = RAM[pc[ADDR_W+1:2]] only when state==RUN, pc[1:0]==0, and pc[31:ADDR_W+2]==0.
  - Otherwise instr = NOP_WORD. Covers misaligned PC, out-of-range PC, and any non-RUN state.
- core_hold = (state != RUN), registered via state; deasserts the cycle after the final byte is accepted.
- Reset asserted mid-session: immediate return to reset state. Partial words are lost; words already written remain in RAM.
- load_valid while load_ready=0: ignored, no state change.

Test Plan:
- Reset with START_HELD=1 -> core_hold=1, load_ready=0, instr=0x00000013 for pc=0.
- load_start; bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 -> core_hold falls one cycle after last byte; words_loaded=2; pc=0 -> 0x00100513; pc=4 -> 0x00200593; pc=8 -> reads RAM[2] (unchanged).
- In RUN: pc=0x2 -> 0x00000013; pc=1<<(ADDR_W+2) -> 0x00000013.
- Header N=0 -> RUN right after 4th header byte; words_loaded=0; core_hold=0.
- ADDR_W=2, header N=6, 6 words streamed -> overflow=1; words_loaded=4; RAM holds words 0-3; RUN entered after 24th data byte.
- Mid-DATA: load_start coinciding with a valid byte -> byte dropped, state HDR; next 4 bytes are the new header. Separately, reset mid-DATA -> state HOLD, earlier words retained.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: serves the IF stage from a word RAM that is
// filled through a byte-serial loader stream, and stalls the core until loading finishes.
module instr_mem_responder #(
   parameter int          ADDR_W     = 10,
   parameter logic [31:0] NOP_WORD   = 32'h00000013,
   parameter bit          START_HELD = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc,
   output logic [31:0]       instr,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [7:0]        load_byte,
   output logic              load_ready,
   output logic              core_hold,
   output logic [ADDR_W:0]   words_loaded,
   output logic              overflow
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [32:0]     DEPTH_W = 33'(DEPTH);
   localparam logic [ADDR_W:0] WL_MAX  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {HOLD, HDR, DATA, RUN} state_t;
   localparam state_t RST_STATE = START_HELD ? HOLD : RUN;

   state_t      state, state_nx;
   logic [1:0]  byte_cnt;
   logic [23:0] shreg;
   logic [31:0] word_cnt;
   logic [31:0] declared_n;
   logic [31:0] full_word;
   logic        xfer;
   logic        word_done;
   logic        wr_en;
   logic        in_range;
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RST_STATE;
      else        state <= state_nx;
   end

   // A 4th byte completes a word; load_start wins over any byte in the same cycle.
   always_comb begin
      state_nx   = state;
      load_ready = (state == HDR) || (state == DATA);
      core_hold  = (state != RUN);
      xfer       = load_valid && load_ready;
      full_word  = {load_byte, shreg};
      word_done  = xfer && (byte_cnt == 2'd3) && !load_start;
      wr_en      = 1'b0;
      if (load_start) begin
         state_nx = HDR;
      end else if (word_done) begin
         case (state)
            HDR:  state_nx = (full_word == 32'd0) ? RUN : DATA;
            DATA: begin
               wr_en = ({1'b0, word_cnt} < DEPTH_W);
               if (word_cnt + 32'd1 == declared_n) state_nx = RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_cnt     <= 2'd0;
         word_cnt     <= 32'd0;
         declared_n   <= 32'd0;
         words_loaded <= '0;
         overflow     <= 1'b0;
      end else if (load_start) begin
         byte_cnt     <= 2'd0;
         word_cnt     <= 32'd0;
         words_loaded <= '0;
         overflow     <= 1'b0;
      end else if (xfer) begin
         byte_cnt <= byte_cnt + 2'd1;
         if (byte_cnt == 2'd3) begin
            if (state == HDR) begin
               declared_n <= full_word;
               overflow   <= ({1'b0, full_word} > DEPTH_W);
            end else begin
               word_cnt <= word_cnt + 32'd1;
               if (words_loaded != WL_MAX) words_loaded <= words_loaded + (ADDR_W + 1)'(1);
            end
         end
      end
   end

   // Little-endian assembly: the newest byte enters at the top and shifts down.
   always_ff @(posedge clk) begin
      if (xfer && !load_start) shreg <= {load_byte, shreg[23:8]};
      if (wr_en) mem[word_cnt[ADDR_W-1:0]] <= full_word;
   end

   always_comb begin
      in_range = ((pc >> (ADDR_W + 2)) == 32'd0);
      if ((state == RUN) && (pc[1:0] == 2'b00) && in_range) instr = mem[pc[ADDR_W+1:2]];
      else                                                   instr = NOP_WORD;
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder (ADDR_W=2): vector table, hand-built corner
// sequences, then randomized sessions checked against a byte-stream reference model.
module tb_instr_mem_responder;

   localparam int          ADDR_W = 2;
   localparam int          DEPTH  = 1 << ADDR_W;
   localparam logic [31:0] NOP    = 32'h00000013;
   localparam int M_HOLD = 0, M_HDR = 1, M_DATA = 2, M_RUN = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       pc;
   logic [31:0]       instr;
   logic              load_start, load_valid;
   logic [7:0]        load_byte;
   logic              load_ready, core_hold, overflow;
   logic [ADDR_W:0]   words_loaded;

   int n_cmp = 0;
   int n_bad = 0;

   instr_mem_responder #(.ADDR_W(ADDR_W), .NOP_WORD(NOP), .START_HELD(1'b1)) u_dut (
      .clk(clk), .reset(reset), .pc(pc), .instr(instr),
      .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
      .load_ready(load_ready), .core_hold(core_hold),
      .words_loaded(words_loaded), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference model: a session is a byte stream; groups of 4 bytes form words.
   int          m_mode;
   logic [7:0]  mq[$];
   longint      m_n;
   int          m_nw;
   bit          m_ovf;
   logic [31:0] m_mem [DEPTH];
   bit          m_known [DEPTH];

   task automatic model_reset();
      m_mode = M_HOLD; mq.delete(); m_nw = 0; m_ovf = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit v, input logic [7:0] b);
      logic [31:0] w;
      if (s) begin
         m_mode = M_HDR; mq.delete(); m_nw = 0; m_ovf = 1'b0;
      end else if (v && (m_mode == M_HDR || m_mode == M_DATA)) begin
         mq.push_back(b);
         if (mq.size() == 4) begin
            w = {mq[3], mq[2], mq[1], mq[0]};
            mq.delete();
            if (m_mode == M_HDR) begin
               m_n    = longint'(w);
               m_ovf  = (m_n > DEPTH);
               m_mode = (m_n == 0) ? M_RUN : M_DATA;
            end else begin
               if (m_nw < DEPTH) begin
                  m_mem[m_nw] = w; m_known[m_nw] = 1'b1;
               end
               m_nw++;
               if (m_nw == m_n) m_mode = M_RUN;
            end
         end
      end
   endtask

   function automatic bit model_ready();
      return (m_mode == M_HDR) || (m_mode == M_DATA);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      int idx;
      chk({name, ".hold"},  32'(core_hold),    32'(m_mode != M_RUN));
      chk({name, ".ready"}, 32'(load_ready),   32'(model_ready()));
      chk({name, ".wl"},    32'(words_loaded), 32'((m_nw < DEPTH) ? m_nw : DEPTH));
      chk({name, ".ovf"},   32'(overflow),     32'(m_ovf));
      if (m_mode != M_RUN || pc[1:0] != 2'b00 || pc >= 32'(4 * DEPTH)) begin
         chk({name, ".instr"}, instr, NOP);
      end else begin
         idx = int'(pc >> 2);
         if (m_known[idx]) chk({name, ".instr"}, instr, m_mem[idx]);
      end
   endtask

   // Inputs change at negedge; the model follows the DUT at posedge; checks at the next negedge.
   task automatic cycle(input bit s, input bit v, input logic [7:0] b, input logic [31:0] p);
      load_start = s; load_valid = v; load_byte = b; pc = p;
      @(posedge clk);
      model_step(s, v, b);
      @(negedge clk);
   endtask

   task automatic send32(input logic [31:0] w, input logic [31:0] p);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, w[8*i +: 8], p);
   endtask

   task automatic do_reset();
      load_start = 1'b0; load_valid = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      check_model("rst_async");
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      bit          s;
      bit          v;
      logic [7:0]  b;
      logic [31:0] p;
      bit          hold;
      bit          rdy;
      int          wl;
      bit          ovf;
      logic [31:0] ins;
      bit          chk_ins;
   } vec_t;

   function automatic vec_t mk(bit s, bit v, logic [7:0] b, logic [31:0] p, bit hold, bit rdy,
                               int wl, bit ovf, logic [31:0] ins, bit ci);
      vec_t r;
      r.s = s; r.v = v; r.b = b; r.p = p; r.hold = hold; r.rdy = rdy;
      r.wl = wl; r.ovf = ovf; r.ins = ins; r.chk_ins = ci;
      return r;
   endfunction

   vec_t tbl[$];

   initial begin
      logic [7:0]  stream[$];
      logic [31:0] rp;
      int          n, idx, guard, r;
      bit          v, rdy;

      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
      reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00; pc = 32'h0;
      model_reset();
      @(negedge clk); @(negedge clk);
      chk("reset.hold",  32'(core_hold),    32'd1);
      chk("reset.ready", 32'(load_ready),   32'd0);
      chk("reset.wl",    32'(words_loaded), 32'd0);
      chk("reset.ovf",   32'(overflow),     32'd0);
      chk("reset.instr", instr,             NOP);
      reset = 1'b1;
      @(negedge clk);

      // Two-word load, then reads in RUN.
      tbl.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h02, 0, 1, 1, 0, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h13, 0, 1, 1, 0, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h05, 0, 1, 1, 0, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h10, 0, 1, 1, 0, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h00, 0, 1, 1, 1, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h93, 0, 1, 1, 1, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h05, 0, 1, 1, 1, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h20, 0, 1, 1, 1, 0, NOP, 1));
      tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 2, 0, 32'h00100513, 1));
      tbl.push_back(mk(0, 0, 8'h00, 4, 0, 0, 2, 0, 32'h00200593, 1));
      tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 2, 0, 32'h00100513, 1));
      tbl.push_back(mk(0, 0, 8'h00, 2, 0, 0, 2, 0, NOP, 1));
      tbl.push_back(mk(0, 0, 8'h00, 32'h10, 0, 0, 2, 0, NOP, 1));
      tbl.push_back(mk(0, 0, 8'h00, 32'h80000000, 0, 0, 2, 0, NOP, 1));
      tbl.push_back(mk(0, 0, 8'h00, 3, 0, 0, 2, 0, NOP, 1));
      tbl.push_back(mk(0, 0, 8'h00, 8, 0, 0, 2, 0, NOP, 0));
      foreach (tbl[i]) begin
         cycle(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].p);
         chk($sformatf("tbl%0d.hold", i),  32'(core_hold),    32'(tbl[i].hold));
         chk($sformatf("tbl%0d.ready", i), 32'(load_ready),   32'(tbl[i].rdy));
         chk($sformatf("tbl%0d.wl", i),    32'(words_loaded), 32'(tbl[i].wl));
         chk($sformatf("tbl%0d.ovf", i),   32'(overflow),     32'(tbl[i].ovf));
         if (tbl[i].chk_ins) chk($sformatf("tbl%0d.instr", i), instr, tbl[i].ins);
      end

      // Empty session: RUN right after the 4th header byte.
      cycle(1, 0, 8'h00, 0);
      send32(32'd0, 32'd4);
      chk("n0.hold",  32'(core_hold),    32'd0);
      chk("n0.wl",    32'(words_loaded), 32'd0);
      chk("n0.ready", 32'(load_ready),   32'd0);
      chk("n0.instr", instr,             32'h00200593);

      // Declared count beyond depth: extra words consumed and discarded.
      cycle(1, 0, 8'h00, 0);
      send32(32'd6, 0);
      chk("ovf.flag_hdr", 32'(overflow),  32'd1);
      chk("ovf.hold_hdr", 32'(core_hold), 32'd1);
      for (int i = 0; i < 5; i++) send32(32'hA0000000 + 32'(i), 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 8'hEE, 0);
      chk("ovf.hold_b23", 32'(core_hold), 32'd1);
      cycle(0, 1, 8'hEE, 0);
      chk("ovf.hold_b24", 32'(core_hold),    32'd0);
      chk("ovf.wl",       32'(words_loaded), 32'd4);
      chk("ovf.flag",     32'(overflow),     32'd1);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 8'h00, 32'(4 * i));
         chk($sformatf("ovf.ram%0d", i), instr, 32'hA0000000 + 32'(i));
      end

      // Restart mid-word: the coinciding byte is dropped, next 4 bytes are a new header.
      cycle(1, 0, 8'h00, 0);
      send32(32'd3, 0);
      send32(32'h44332211, 0);
      cycle(0, 1, 8'h77, 0);
      cycle(0, 1, 8'h66, 0);
      cycle(1, 1, 8'h55, 0);
      chk("rst_hdr.hold",  32'(core_hold),    32'd1);
      chk("rst_hdr.ready", 32'(load_ready),   32'd1);
      chk("rst_hdr.wl",    32'(words_loaded), 32'd0);
      send32(32'd1, 0);
      chk("rst_hdr.data", 32'(core_hold), 32'd1);
      send32(32'hCAFEF00D, 0);
      chk("rst_hdr.run",   32'(core_hold),    32'd0);
      chk("rst_hdr.wl1",   32'(words_loaded), 32'd1);
      chk("rst_hdr.instr", instr,             32'hCAFEF00D);

      // Reset mid-DATA: back to HOLD, written words survive.
      cycle(1, 0, 8'h00, 0);
      send32(32'd2, 0);
      send32(32'hDEADBEEF, 0);
      cycle(0, 1, 8'h01, 0);
      cycle(0, 1, 8'h02, 0);
      do_reset();
      chk("midrst.hold",  32'(core_hold),    32'd1);
      chk("midrst.ready", 32'(load_ready),   32'd0);
      chk("midrst.wl",    32'(words_loaded), 32'd0);
      cycle(1, 0, 8'h00, 0);
      send32(32'd0, 0);
      chk("midrst.ram0", instr, 32'hDEADBEEF);
      cycle(0, 0, 8'h00, 4);
      chk("midrst.ram1", instr, 32'hA0000001);

      // Randomized sessions with gaps, restarts and resets.
      for (int sess = 0; sess < 60; sess++) begin
         n = $urandom_range(0, 6);
         stream.delete();
         for (int i = 0; i < 4; i++) stream.push_back(8'((n >> (8 * i)) & 255));
         for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom_range(0, 255)));
         cycle(1, 0, 8'h00, 0);
         check_model("rnd.start");
         idx = 0; guard = 0;
         while (idx < stream.size() && guard < 300) begin
            guard++;
            r = $urandom_range(0, 199);
            case ($urandom_range(0, 3))
               0:       rp = 32'(4 * $urandom_range(0, DEPTH + 1));
               1:       rp = 32'($urandom_range(0, 4 * DEPTH + 3));
               2:       rp = 32'h1 << (ADDR_W + 2);
               default: rp = $urandom;
            endcase
            if (r == 0) begin
               do_reset();
            end else if (r < 3) begin
               cycle(1, $urandom_range(0, 1) == 1, stream[idx], rp);
            end else begin
               v   = (r < 140);
               rdy = model_ready();
               cycle(0, v, stream[idx], rp);
               if (v && rdy) idx++;
            end
            check_model("rnd");
         end
         for (int k = 0; k < 4; k++) begin
            cycle(0, $urandom_range(0, 1) == 1, 8'($urandom), 32'(4 * $urandom_range(0, DEPTH - 1)));
            check_model("rnd.idle");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
